// File: rtl/inst_decoder.sv
// Registered instruction decoder for the 16-bit teaching CPU: one INST per cycle in, operand
// selects/enables/immediate out one cycle later. Define DECODER_SIGNEXT_EN to sign-extend imm9.
module inst_decoder (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] INST,
    output logic [3:0]  OP,
    output logic [2:0]  LSEL,
    output logic [2:0]  RSEL,
    output logic [2:0]  OSEL,
    output logic        LOUT,
    output logic        ROUT,
    output logic        OIN,
    output logic [15:0] Rbus
);

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_ADD   = 4'h1;
    localparam logic [3:0] OPC_SUB   = 4'h2;
    localparam logic [3:0] OPC_AND   = 4'h3;
    localparam logic [3:0] OPC_OR    = 4'h4;
    localparam logic [3:0] OPC_XOR   = 4'h5;
    localparam logic [3:0] OPC_NOT   = 4'h6;
    localparam logic [3:0] OPC_SHL   = 4'h7;
    localparam logic [3:0] OPC_SHR   = 4'h8;
    localparam logic [3:0] OPC_MOV   = 4'h9;
    localparam logic [3:0] OPC_LOADI = 4'hA;

    logic [3:0]  inst_op;
    logic [2:0]  inst_d;
    logic [2:0]  inst_s1;
    logic [2:0]  inst_s2;
    logic [8:0]  inst_imm9;
    logic [15:0] imm_ext;

    logic [3:0]  op_d,   op_q;
    logic [2:0]  lsel_d, lsel_q;
    logic [2:0]  rsel_d, rsel_q;
    logic [2:0]  osel_d, osel_q;
    logic        lout_d, lout_q;
    logic        rout_d, rout_q;
    logic        oin_d,  oin_q;
    logic [15:0] rbus_d, rbus_q;

    assign inst_op   = INST[15:12];
    assign inst_d    = INST[11:9];
    assign inst_s1   = INST[8:6];
    assign inst_s2   = INST[5:3];
    assign inst_imm9 = INST[8:0];

`ifdef DECODER_SIGNEXT_EN
    assign imm_ext = {{7{inst_imm9[8]}}, inst_imm9};
`else
    assign imm_ext = {7'b0, inst_imm9};
`endif

    // Reserved opcodes B-F fall into the default arm and decode exactly like NOP.
    always_comb begin
        op_d   = OPC_NOP;
        lsel_d = 3'd0;
        rsel_d = 3'd0;
        osel_d = 3'd0;
        lout_d = 1'b0;
        rout_d = 1'b0;
        oin_d  = 1'b0;
        rbus_d = 16'h0000;
        case (inst_op)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR: begin
                op_d   = inst_op;
                osel_d = inst_d;
                lsel_d = inst_s1;
                rsel_d = inst_s2;
                lout_d = 1'b1;
                rout_d = 1'b1;
                oin_d  = 1'b1;
            end
            OPC_NOT, OPC_MOV: begin
                op_d   = inst_op;
                osel_d = inst_d;
                lsel_d = inst_s1;
                lout_d = 1'b1;
                oin_d  = 1'b1;
            end
            OPC_LOADI: begin
                // Right bus carries the immediate, so no register may drive it.
                op_d   = OPC_LOADI;
                osel_d = inst_d;
                oin_d  = 1'b1;
                rbus_d = imm_ext;
            end
            default: begin
                op_d = OPC_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            op_q   <= 4'h0;
            lsel_q <= 3'd0;
            rsel_q <= 3'd0;
            osel_q <= 3'd0;
            lout_q <= 1'b0;
            rout_q <= 1'b0;
            oin_q  <= 1'b0;
            rbus_q <= 16'h0000;
        end else begin
            op_q   <= op_d;
            lsel_q <= lsel_d;
            rsel_q <= rsel_d;
            osel_q <= osel_d;
            lout_q <= lout_d;
            rout_q <= rout_d;
            oin_q  <= oin_d;
            rbus_q <= rbus_d;
        end
    end

    assign OP   = op_q;
    assign LSEL = lsel_q;
    assign RSEL = rsel_q;
    assign OSEL = osel_q;
    assign LOUT = lout_q;
    assign ROUT = rout_q;
    assign OIN  = oin_q;
    assign Rbus = rbus_q;

endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder: each vector is applied for one edge and the full decoded
// bundle {OP,LSEL,RSEL,OSEL,LOUT,ROUT,OIN,Rbus} is compared against a hand-computed value.
module tb_inst_decoder;

    logic        clk;
    logic        res;
    logic [15:0] INST;
    logic [3:0]  OP;
    logic [2:0]  LSEL;
    logic [2:0]  RSEL;
    logic [2:0]  OSEL;
    logic        LOUT;
    logic        ROUT;
    logic        OIN;
    logic [15:0] Rbus;

    int checks;
    int errors;

    inst_decoder dut (
        .clk  (clk),
        .res  (res),
        .INST (INST),
        .OP   (OP),
        .LSEL (LSEL),
        .RSEL (RSEL),
        .OSEL (OSEL),
        .LOUT (LOUT),
        .ROUT (ROUT),
        .OIN  (OIN),
        .Rbus (Rbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic [3:0] op, input logic [2:0] lsel,
                                         input logic [2:0] rsel, input logic [2:0] osel,
                                         input logic lout, input logic rout, input logic oin,
                                         input logic [15:0] rbus);
        return {op, lsel, rsel, osel, lout, rout, oin, rbus};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Drive on the falling edge, let one rising edge register it, sample 1 ns later.
    task automatic apply(input string tag, input logic r, input logic [15:0] inst,
                         input logic [31:0] expected);
        @(negedge clk);
        res  = r;
        INST = inst;
        @(posedge clk);
        #1;
        check(tag, pack(OP, LSEL, RSEL, OSEL, LOUT, ROUT, OIN, Rbus), expected);
    endtask

    logic [15:0] neg_imm_exp;

    initial begin
        checks = 0;
        errors = 0;
        res    = 1'b1;
        INST   = 16'hAFF0;
`ifdef DECODER_SIGNEXT_EN
        neg_imm_exp = 16'hFFF0;
`else
        neg_imm_exp = 16'h01F0;
`endif

        apply("reset",        1'b1, 16'hAFF0, pack(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000));
        apply("loadi_r1_6",   1'b0, 16'hA206, pack(4'hA, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 16'h0006));
        apply("loadi_r2_3",   1'b0, 16'hA403, pack(4'hA, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 16'h0003));
        apply("add",          1'b0, 16'h1650, pack(4'h1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 16'h0000));
        apply("sub",          1'b0, 16'h26C8, pack(4'h2, 3'd3, 3'd1, 3'd3, 1'b1, 1'b1, 1'b1, 16'h0000));
        apply("loadi_neg",    1'b0, 16'hAFF0, pack(4'hA, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1, neg_imm_exp));
        apply("loadi_pos",    1'b0, 16'hA0FF, pack(4'hA, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h00FF));
        apply("reserved_c",   1'b0, 16'hCFFF, pack(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000));
        apply("nop",          1'b0, 16'h0FFF, pack(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000));
        apply("not",          1'b0, 16'h6975, pack(4'h6, 3'd5, 3'd0, 3'd4, 1'b1, 1'b0, 1'b1, 16'h0000));
        apply("mov",          1'b0, 16'h939F, pack(4'h9, 3'd6, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0000));
        apply("shr",          1'b0, 16'h8ABF, pack(4'h8, 3'd2, 3'd7, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000));
        apply("xor_lowbits",  1'b0, 16'h5DE2, pack(4'h5, 3'd7, 3'd4, 3'd6, 1'b1, 1'b1, 1'b1, 16'h0000));
        apply("reserved_f",   1'b0, 16'hFABC, pack(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000));
        apply("add_before",   1'b0, 16'h1650, pack(4'h1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 16'h0000));
        apply("midreset",     1'b1, 16'h1650, pack(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000));
        apply("add_resume",   1'b0, 16'h1650, pack(4'h1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 16'h0000));
        apply("reset_loadi",  1'b1, 16'hA206, pack(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000));
        apply("loadi_resume", 1'b0, 16'hA206, pack(4'hA, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 16'h0006));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
